nmr_acq_capture: RTL and testbench
==================================

Name: nmr_acq_capture

Overview:
- Receive-side counterpart of the NMR pulse sequencer.
- Consumes the sequencer's FSMSTAT, ACQ_WND and ADC_CLK outputs, and captures ADC samples on each ADC_CLK rising edge while ACQ_WND is high.
- Packs two samples per 32-bit word and buffers the words in a first-word-fall-through FIFO, drained through a valid/ready stream toward the host DMA.
- Reports per-scan sample and echo counts, overflow, and an end-of-scan pulse.

Parameters:
ADC_WIDTH, 14, width of ADC_DATA; must be ≤ 16; zero-extended into 16-bit half-words.
FIFO_AW, 9, FIFO address width; depth = 2^FIFO_AW words.
DATABUS_WIDTH, 32, width of DOUT, SAMPLE_CNT and ECHO_CNT.

Ports:
CLK  in  1  system clock; the same clock that drives the sequencer.
RESET_N  in  1  asynchronous, active-low reset.
FSMSTAT  in  1  sequencer busy; high for the whole scan.
ACQ_WND  in  1  acquisition window from the sequencer.
ADC_CLK  in  1  ADC clock from the sequencer (CLK/4), synchronous to CLK.
ADC_DATA  in  ADC_WIDTH  ADC output word, valid at the ADC_CLK rising edge.
DOUT  out  DATABUS_WIDTH  FIFO head word; {sample_odd, sample_even}, with the even-index sample in [15:0].
DOUT_VALID  out  1  FIFO not empty.
DOUT_READY  in  1  consumer accepts DOUT this cycle.
BUSY  out  1  high from FSMSTAT rise until the flush completes.
SAMPLE_CNT  out  DATABUS_WIDTH  samples captured in the current or last scan.
ECHO_CNT  out  DATABUS_WIDTH  ACQ_WND rising edges in the current or last scan.
OVERFLOW  out  1  sticky; a word was dropped because the FIFO was full.
DONE  out  1  one-cycle pulse when a scan's flush completes.

Behaviour:
- Reset (RESET_N low, asynchronous): all outputs go to 0 (DOUT 0, DOUT_VALID 0, counts 0, OVERFLOW 0, DONE 0, BUSY 0), FIFO empty, half-word pending flag clear, state IDLE. Reset mid-scan discards all data.
- Edge detect: ADC_CLK, ACQ_WND and FSMSTAT are each registered once.
  - adc_rise = ADC_CLK & ~ADC_CLK_q.
  - Sample strobe = adc_rise & ACQ_WND & (state == ACQ), using the unregistered ADC_CLK, ACQ_WND and ADC_DATA of that cycle.
- State machine (one-hot):
  - IDLE: on FSMSTAT rise, clear SAMPLE_CNT, ECHO_CNT, OVERFLOW and the pending flag, set BUSY, go to ARMED. The FIFO is not cleared, so a prior scan's unread words remain.
  - ARMED: on ACQ_WND rise, ECHO_CNT +1 and go to ACQ. On FSMSTAT fall, go to FLUSH.
  - ACQ: capture on each strobe. On ACQ_WND fall, go to ARMED. On FSMSTAT fall, go to FLUSH; this takes priority over the ACQ_WND fall.
  - FLUSH: if a half-word is pending, push {16'h0, pending} and clear the pending flag. Go to FIN.
  - FIN: DONE = 1 for one cycle, BUSY = 0, go to IDLE.
- Packing:
  - Packing is continuous across echoes. Only FLUSH pads.
  - Even-index sample: stored in the low half, pending flag set.
  - Odd-index sample: forms the full word, raises push_req for one cycle, pending flag cleared.
  - Total words per scan = ceil(SAMPLE_CNT / 2).
- Latency: a strobe in cycle n that completes a word gives push in cycle n+1, and DOUT_VALID in cycle n+2 if the FIFO was empty.
- FIFO:
  - Pop when DOUT_VALID & DOUT_READY.
  - A push is accepted if count < depth, or if a pop happens in the same cycle (simultaneous push and pop when full is legal).
  - Otherwise the word is dropped and OVERFLOW is set, held until the next FSMSTAT rise or reset.
  - Pointers wrap modulo depth. The count register is FIFO_AW+1 bits.
  - DOUT holds steady while DOUT_VALID is high and DOUT_READY is low.
  - DOUT_READY while empty has no effect.
- Counters:
  - SAMPLE_CNT increments on every strobe, including strobes whose word is later dropped.
  - SAMPLE_CNT and ECHO_CNT wrap modulo 2^DATABUS_WIDTH.
  - Both hold their value after DONE until the next scan starts.
- ADC_CLK edges outside ACQ_WND, or outside a scan, are ignored.
- An ACQ_WND rise while in IDLE is ignored.

Test Plan:
- Single echo: FSMSTAT high, one 40-CLK ACQ_WND, ADC_CLK = CLK/4, ADC_DATA = ramp 1..10 -> 10 samples, 5 words 0x00020001..0x000A0009, SAMPLE_CNT = 10, ECHO_CNT = 1, one DONE pulse, OVERFLOW = 0.
- Odd sample count with flush: 3 echoes of 3 samples each (values 0x11..0x19) -> 5 words, last word = 0x00000019, SAMPLE_CNT = 9, ECHO_CNT = 3.
- Backpressure/overflow: FIFO_AW = 2, DOUT_READY = 0, 12 samples -> 4 words stored, OVERFLOW = 1. After DOUT_READY = 1, exactly the first 4 words are read out in order.
- Full with simultaneous pop: FIFO full, DOUT_READY = 1 in the same cycle as a push -> no drop, OVERFLOW stays 0, count stays at 4.
- FSMSTAT falls mid-window after 5 samples -> FLUSH pads the 5th sample, 3 words total, DONE asserted 2 cycles after the FSMSTAT fall is registered.
- RESET_N pulsed low mid-ACQ -> all outputs 0 immediately (asynchronous); the next scan starts clean with SAMPLE_CNT counting from 0.

Source files
------------

// File: rtl/nmr_acq_capture.sv
// nmr_acq_capture: captures ADC samples inside sequencer acquisition windows, packs two per word into a FWFT FIFO with scan counters
module nmr_acq_capture #(
  parameter int ADC_WIDTH = 14,
  parameter int FIFO_AW = 9,
  parameter int DATABUS_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     FSMSTAT,
  input  logic                     ACQ_WND,
  input  logic                     ADC_CLK,
  input  logic [ADC_WIDTH-1:0]     ADC_DATA,
  output logic [DATABUS_WIDTH-1:0] DOUT,
  output logic                     DOUT_VALID,
  input  logic                     DOUT_READY,
  output logic                     BUSY,
  output logic [DATABUS_WIDTH-1:0] SAMPLE_CNT,
  output logic [DATABUS_WIDTH-1:0] ECHO_CNT,
  output logic                     OVERFLOW,
  output logic                     DONE
);
  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_ARMED = 5'b00010;
  localparam logic [4:0] S_ACQ   = 5'b00100;
  localparam logic [4:0] S_FLUSH = 5'b01000;
  localparam logic [4:0] S_FIN   = 5'b10000;
  localparam int DEPTH = 1 << FIFO_AW;
  logic [4:0] state, state_nxt;
  logic adc_clk_q, acq_wnd_q, fsmstat_q;
  logic adc_rise, acq_rise, acq_fall, fsm_rise, fsm_fall, strobe;
  logic [15:0] sample, pend;
  logic pend_v, push_req, push_ok, pop;
  logic [31:0] push_word;
  logic [31:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  assign adc_rise = ADC_CLK & ~adc_clk_q;
  assign acq_rise = ACQ_WND & ~acq_wnd_q;
  assign acq_fall = ~ACQ_WND & acq_wnd_q;
  assign fsm_rise = FSMSTAT & ~fsmstat_q;
  assign fsm_fall = ~FSMSTAT & fsmstat_q;
  assign strobe = adc_rise & ACQ_WND & (state == S_ACQ);
  assign sample = 16'(ADC_DATA);
  assign BUSY = |(state & (S_ARMED | S_ACQ | S_FLUSH));
  assign DONE = (state == S_FIN);
  assign DOUT_VALID = |count;
  assign DOUT = DOUT_VALID ? DATABUS_WIDTH'(mem[rd_ptr]) : '0;
  assign pop = DOUT_VALID & DOUT_READY;
  assign push_ok = push_req & (~count[FIFO_AW] | pop);
  always_comb begin
    state_nxt = S_IDLE;
    unique case (state)
      S_IDLE:  state_nxt = fsm_rise ? S_ARMED : S_IDLE;
      S_ARMED: state_nxt = fsm_fall ? S_FLUSH : acq_rise ? S_ACQ : S_ARMED;
      S_ACQ:   state_nxt = fsm_fall ? S_FLUSH : acq_fall ? S_ARMED : S_ACQ;
      S_FLUSH: state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
      adc_clk_q <= 1'b0;
      acq_wnd_q <= 1'b0;
      fsmstat_q <= 1'b0;
      pend <= '0;
      pend_v <= 1'b0;
      push_req <= 1'b0;
      push_word <= '0;
      SAMPLE_CNT <= '0;
      ECHO_CNT <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      state <= state_nxt;
      adc_clk_q <= ADC_CLK;
      acq_wnd_q <= ACQ_WND;
      fsmstat_q <= FSMSTAT;
      push_req <= 1'b0;
      if (push_req && !push_ok)
        OVERFLOW <= 1'b1;
      if (state == S_IDLE && fsm_rise) begin
        SAMPLE_CNT <= '0;
        ECHO_CNT <= '0;
        OVERFLOW <= 1'b0;
        pend_v <= 1'b0;
      end
      if (state == S_ARMED && state_nxt == S_ACQ)
        ECHO_CNT <= ECHO_CNT + 1'b1;
      if (strobe) begin
        SAMPLE_CNT <= SAMPLE_CNT + 1'b1;
        pend_v <= ~pend_v;
        if (pend_v) begin
          push_req <= 1'b1;
          push_word <= {sample, pend};
        end else
          pend <= sample;
      end
      if (state == S_FLUSH && pend_v) begin
        push_req <= 1'b1;
        push_word <= {16'h0, pend};
        pend_v <= 1'b0;
      end
    end
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{FIFO_AW{1'b0}}, push_ok} - {{FIFO_AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge CLK)
    if (push_ok)
      mem[wr_ptr] <= push_word;
endmodule

// File: tb/tb_nmr_acq_capture.sv
// tb_nmr_acq_capture: randomized scoreboard bench for nmr_acq_capture with a behavioural scan model
module tb_nmr_acq_capture;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic FSMSTAT = 1'b0;
  logic ACQ_WND = 1'b0;
  logic ADC_CLK = 1'b0;
  logic DOUT_READY = 1'b0;
  logic [13:0] ADC_DATA = '0;
  logic [31:0] DOUT, SAMPLE_CNT, ECHO_CNT;
  logic DOUT_VALID, BUSY, OVERFLOW, DONE;
  int checks = 0;
  int errors = 0;
  nmr_acq_capture #(.ADC_WIDTH(14), .FIFO_AW(AW), .DATABUS_WIDTH(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FSMSTAT(FSMSTAT), .ACQ_WND(ACQ_WND), .ADC_CLK(ADC_CLK),
    .ADC_DATA(ADC_DATA), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .BUSY(BUSY), .SAMPLE_CNT(SAMPLE_CNT), .ECHO_CNT(ECHO_CNT), .OVERFLOW(OVERFLOW), .DONE(DONE)
  );
  always #5 CLK = ~CLK;
  logic [31:0] expq [$];
  int mcnt, ph, rmode, pops;
  logic [31:0] mscnt, mecnt, push_w, last_pop;
  logic [15:0] mpend;
  logic movf, mbusy, mdone, mfl, push_v, pf, pw, padc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    expq.delete();
    mcnt = 0; mscnt = 0; mecnt = 0; mpend = 0; push_w = 0;
    movf = 0; mbusy = 0; mdone = 0; mfl = 0; push_v = 0; pf = 0; pw = 0; padc = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, DOUT, 32'h0);
    chk({tag, "_valid"}, 32'(DOUT_VALID), 32'h0);
    chk({tag, "_busy"}, 32'(BUSY), 32'h0);
    chk({tag, "_done"}, 32'(DONE), 32'h0);
    chk({tag, "_samples"}, SAMPLE_CNT, 32'h0);
    chk({tag, "_echoes"}, ECHO_CNT, 32'h0);
    chk({tag, "_overflow"}, 32'(OVERFLOW), 32'h0);
  endtask
  initial forever begin
    @(negedge CLK);
    #2;
    if (RESET_N && DOUT_VALID && DOUT_READY) begin
      pops++;
      last_pop = DOUT;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout: got %h but no word expected", DOUT);
      end else
        chk("dout", DOUT, expq.pop_front());
    end
  end
  task automatic step(input logic f, input logic w, input logic [13:0] d);
    logic rdy, a, pop, strobe;
    @(negedge CLK);
    chk("valid", 32'(DOUT_VALID), 32'(mcnt > 0));
    chk("busy", 32'(BUSY), 32'(mbusy));
    chk("done", 32'(DONE), 32'(mdone));
    chk("sample_cnt", SAMPLE_CNT, mscnt);
    chk("echo_cnt", ECHO_CNT, mecnt);
    chk("overflow", 32'(OVERFLOW), 32'(movf));
    #1;
    ph++;
    a = ph[1];
    rdy = rmode == 0 ? 1'b0 : rmode == 1 ? 1'b1 : rmode == 2 ? ($urandom_range(9, 0) < 7) : (push_v && mcnt == DEPTH);
    FSMSTAT = f;
    ACQ_WND = w;
    ADC_CLK = a;
    ADC_DATA = d;
    DOUT_READY = rdy;
    pop = mcnt > 0 && rdy;
    if (push_v) begin
      if (mcnt < DEPTH || pop) begin
        expq.push_back(push_w);
        mcnt++;
      end else
        movf = 1;
    end
    if (pop)
      mcnt--;
    push_v = 0;
    mdone = 0;
    if (mfl) begin
      if (mscnt[0]) begin
        push_v = 1;
        push_w = {16'h0, mpend};
      end
      mfl = 0;
      mdone = 1;
      mbusy = 0;
    end
    if (f && !pf) begin
      mscnt = 0; mecnt = 0; movf = 0; mbusy = 1;
    end
    if (w && !pw && f && pf)
      mecnt++;
    strobe = a && !padc && w && pw && pf;
    if (strobe) begin
      if (mscnt[0]) begin
        push_v = 1;
        push_w = {2'b0, d, mpend};
      end else
        mpend = {2'b0, d};
      mscnt++;
    end
    if (!f && pf)
      mfl = 1;
    pf = f;
    pw = w;
    padc = a;
  endtask
  task automatic scan(input int nwin, input int wlen, input int fall_at, input logic ramp, input logic [13:0] base);
    logic f;
    f = 1'b1;
    repeat (3) step(1'b1, 1'b0, 14'($urandom));
    for (int i = 0; i < nwin; i++) begin
      if (ramp)
        while (ph % 4 != 2) step(f, 1'b0, 14'($urandom));
      for (int j = 0; j < wlen; j++) begin
        if (i == nwin - 1 && j == fall_at)
          f = 1'b0;
        step(f, 1'b1, ramp ? base + mscnt[13:0] : 14'($urandom));
      end
      repeat ($urandom_range(4, 1)) step(f, 1'b0, 14'($urandom));
    end
    repeat (8) step(1'b0, 1'b0, 14'($urandom));
  endtask
  task automatic drain();
    rmode = 1;
    repeat (12) step(1'b0, 1'b0, 14'($urandom));
  endtask
  initial begin
    int wl;
    model_reset();
    ph = 0;
    rmode = 1;
    pops = 0;
    last_pop = 0;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RESET_N = 1'b1;
    scan(1, 40, -1, 1'b1, 14'd1);
    chk("single_samples", SAMPLE_CNT, 32'd10);
    chk("single_echoes", ECHO_CNT, 32'd1);
    chk("single_overflow", 32'(OVERFLOW), 32'h0);
    chk("single_last", last_pop, 32'h000A0009);
    pops = 0;
    scan(3, 12, -1, 1'b1, 14'h11);
    chk("odd_samples", SAMPLE_CNT, 32'd9);
    chk("odd_echoes", ECHO_CNT, 32'd3);
    chk("odd_words", 32'(pops), 32'd5);
    chk("odd_last", last_pop, 32'h00000019);
    rmode = 0;
    pops = 0;
    scan(1, 48, -1, 1'b1, 14'd1);
    chk("ovf_flag", 32'(OVERFLOW), 32'h1);
    chk("ovf_samples", SAMPLE_CNT, 32'd12);
    drain();
    chk("ovf_words", 32'(pops), 32'd4);
    chk("ovf_last", last_pop, 32'h00080007);
    rmode = 3;
    pops = 0;
    scan(1, 56, -1, 1'b1, 14'd1);
    chk("full_pop_overflow", 32'(OVERFLOW), 32'h0);
    chk("full_pop_words", 32'(pops), 32'd3);
    drain();
    chk("full_pop_total", 32'(pops), 32'd7);
    chk("full_pop_last", last_pop, 32'h000E000D);
    pops = 0;
    scan(1, 30, 21, 1'b1, 14'h21);
    chk("early_samples", SAMPLE_CNT, 32'd5);
    chk("early_words", 32'(pops), 32'd3);
    chk("early_last", last_pop, 32'h00000025);
    repeat (3) step(1'b1, 1'b0, 14'($urandom));
    while (ph % 4 != 2) step(1'b1, 1'b0, 14'($urandom));
    for (int j = 0; j < 15; j++) step(1'b1, 1'b1, 14'h100 + mscnt[13:0]);
    @(negedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    FSMSTAT = 1'b0;
    ACQ_WND = 1'b0;
    step(1'b0, 1'b0, 14'($urandom));
    #2;
    RESET_N = 1'b1;
    scan(1, 20, -1, 1'b1, 14'h5);
    chk("post_reset_samples", SAMPLE_CNT, 32'd5);
    chk("post_reset_last", last_pop, 32'h00000009);
    rmode = 2;
    repeat (12) begin
      wl = $urandom_range(30, 4);
      scan($urandom_range(3, 1), wl, $urandom_range(1, 0) ? -1 : $urandom_range(wl - 1, 1), 1'b0, 14'h0);
    end
    drain();
    chk("queue_empty", 32'(expq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
